// File: rtl/ppm_pkg.sv
// Shared PPM types and default 12 MHz timing constants.
package ppm_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CAPTURE,
    COMMIT
  } ppm_state_t;

  localparam int unsigned DEF_NUM_CH     = 8;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_SYNC_MIN   = 36000;
  localparam int unsigned DEF_PULSE_MIN  = 10800;
  localparam int unsigned DEF_PULSE_MAX  = 25200;
  localparam int unsigned DEF_FS_TIMEOUT = 300000;
  localparam int unsigned DEF_FS_VALUE   = 18000;

  typedef logic [DEF_CNT_W-1:0] ppm_width_t;

endpackage

// File: rtl/ppm_edge_sync.sv
// Two-flop synchronizer for an inverted PPM pin plus a registered rising-edge
// detector on the de-inverted level; a pin transition shows up 3 clocks later.
module ppm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_n_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       level_q;

  // Sync flops reset to the idle (high) pin level so release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      level_q <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sig_n_i};
      level_q <= ~sync_q[1];
      rise_o  <= ~sync_q[1] & ~level_q;
    end
  end

endmodule

// File: rtl/ppm_frame_sequencer.sv
// PPM frame sequencer: sync qualification, per-channel width capture and
// validation, atomic frame commit. Optional failsafe timer: PPM_FAILSAFE_EN.
module ppm_frame_sequencer
  import ppm_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned SYNC_MIN   = DEF_SYNC_MIN,
  parameter int unsigned PULSE_MIN  = DEF_PULSE_MIN,
  parameter int unsigned PULSE_MAX  = DEF_PULSE_MAX,
  parameter int unsigned FS_TIMEOUT = DEF_FS_TIMEOUT,
  parameter int unsigned FS_VALUE   = DEF_FS_VALUE
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    ppm_n_i,
  output logic [NUM_CH*CNT_W-1:0] ch_width_o,
  output logic                    frame_valid_o,
  output logic                    locked_o,
  output logic                    failsafe_o,
  output logic [7:0]              err_cnt_o
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] SYNC_MIN_C  = CNT_W'(SYNC_MIN);
  localparam logic [CNT_W-1:0] PULSE_MIN_C = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] PULSE_MAX_C = CNT_W'(PULSE_MAX);
  localparam logic [CNT_W-1:0] FS_VALUE_C  = CNT_W'(FS_VALUE);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CH - 1);

  if (NUM_CH == 0 || PULSE_MIN > PULSE_MAX || FS_TIMEOUT == 0) begin : g_bad_param
    $error("ppm_frame_sequencer: inconsistent channel/timing parameters");
  end

  logic ppm_edge;

  ppm_edge_sync u_edge_sync (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .sig_n_i (ppm_n_i),
    .rise_o  (ppm_edge)
  );

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width;
  logic             in_bounds;
  logic             capture_err;
  ppm_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] shadow [NUM_CH];

  // Width includes the edge cycle itself, so it equals the pin interval.
  always_comb begin
    width       = (&cnt) ? cnt : cnt + CNT_W'(1);
    in_bounds   = (width >= PULSE_MIN_C) && (width <= PULSE_MAX_C);
    capture_err = 1'b0;
    if (state == CAPTURE) begin
      capture_err = ppm_edge ? !in_bounds : (cnt > PULSE_MAX_C);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt <= '0;
    end else if (ppm_edge) begin
      cnt <= '0;
    end else if (!(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef PPM_FAILSAFE_EN
  localparam int unsigned      TMR_W        = $clog2(FS_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] FS_TIMEOUT_C = TMR_W'(FS_TIMEOUT);

  logic [TMR_W-1:0] fs_timer;
`else
  assign failsafe_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= HUNT;
      idx           <= '0;
      frame_valid_o <= 1'b0;
      locked_o      <= 1'b0;
      err_cnt_o     <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        shadow[k]                    <= '0;
        ch_width_o[k*CNT_W +: CNT_W] <= FS_VALUE_C;
      end
`ifdef PPM_FAILSAFE_EN
      fs_timer   <= '0;
      failsafe_o <= 1'b0;
`endif
    end else begin
      frame_valid_o <= 1'b0;

      unique case (state)
        HUNT: begin
          if (ppm_edge && (width >= SYNC_MIN_C)) begin
            idx   <= '0;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (capture_err) begin
            locked_o <= 1'b0;
            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            state <= HUNT;
          end else if (ppm_edge) begin
            shadow[idx] <= width;
            if (idx == LAST_IDX) state <= COMMIT;
            else                 idx   <= idx + 1'b1;
          end
        end
        COMMIT: begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            ch_width_o[k*CNT_W +: CNT_W] <= shadow[k];
          end
          frame_valid_o <= 1'b1;
          locked_o      <= 1'b1;
          state         <= HUNT;
        end
        default: state <= HUNT;
      endcase

`ifdef PPM_FAILSAFE_EN
      // A commit in the timeout cycle takes priority over the failsafe.
      if (state == COMMIT) begin
        fs_timer   <= '0;
        failsafe_o <= 1'b0;
      end else if (fs_timer == FS_TIMEOUT_C) begin
        failsafe_o <= 1'b1;
        locked_o   <= 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          ch_width_o[k*CNT_W +: CNT_W] <= FS_VALUE_C;
        end
      end else begin
        fs_timer <= fs_timer + TMR_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// Scoreboard bench for ppm_frame_sequencer with timing scaled by 1/100
// (failsafe timeout shortened) so the run stays short.
module tb_ppm_frame_sequencer;

  localparam int NCH  = 8;
  localparam int CW   = 16;
  localparam int SMIN = 360;
  localparam int PMIN = 108;
  localparam int PMAX = 252;
  localparam int FST  = 8000;
  localparam int FSV  = 180;
  localparam int PW   = 30;

  typedef logic [NCH*CW-1:0] frame_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            ppm_n = 1'b1;
  frame_t          ch_width;
  logic            frame_valid;
  logic            locked;
  logic            failsafe;
  logic [7:0]      err_cnt;

  always #5 clk = ~clk;

  ppm_frame_sequencer #(
    .NUM_CH     (NCH),
    .CNT_W      (CW),
    .SYNC_MIN   (SMIN),
    .PULSE_MIN  (PMIN),
    .PULSE_MAX  (PMAX),
    .FS_TIMEOUT (FST),
    .FS_VALUE   (FSV)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .ppm_n_i       (ppm_n),
    .ch_width_o    (ch_width),
    .frame_valid_o (frame_valid),
    .locked_o      (locked),
    .failsafe_o    (failsafe),
    .err_cnt_o     (err_cnt)
  );

  int     n_total  = 0;
  int     n_bad    = 0;
  int     n_commit = 0;
  int     n_pushed = 0;
  frame_t exp_q[$];
  frame_t held;
  frame_t mon_exp;
  frame_t fs_frame;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input frame_t exp, input int tol);
    int a, e;
    for (int i = 0; i < NCH; i++) begin
      a = int'(ch_width[i*CW +: CW]);
      e = int'(exp[i*CW +: CW]);
      n_total++;
      if (a - e > tol || e - a > tol || $isunknown(ch_width[i*CW +: CW])) begin
        n_bad++;
        $display("FAIL %s ch%0d: got %0d expected %0d", name, i, a, e);
      end
    end
  endtask

  function automatic frame_t pack_frame(input int w[NCH]);
    frame_t f;
    for (int i = 0; i < NCH; i++) f[i*CW +: CW] = CW'(w[i]);
    return f;
  endfunction

  // Monitor: every commit strobe pops one expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid === 1'b1) begin
      n_commit++;
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_commit: got commit #%0d expected none", n_commit);
      end else begin
        mon_exp = exp_q.pop_front();
        chk_frame("commit_width", mon_exp, 1);
        chk("locked_at_commit", longint'(locked), 1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Falling pin edge (rising de-inverted edge), then n cycles to the next one.
  task automatic tick(input int n);
    ppm_n = 1'b0;
    cyc(PW);
    ppm_n = 1'b1;
    cyc(n - PW);
  endtask

  task automatic send(input int w[NCH], input int tail);
    for (int i = 0; i < NCH; i++) tick(w[i]);
    tick(tail);
  endtask

  task automatic send_good(input int w[NCH], input int tail);
    exp_q.push_back(pack_frame(w));
    n_pushed++;
    held = pack_frame(w);
    send(w, tail);
  endtask

  int fa[NCH] = '{120, 132, 144, 156, 168, 180, 192, 204};
  int fb[NCH] = '{108, 150, 160, 170, 180, 190, 200, 252};
  int fc[NCH] = '{200, 190, 180, 170, 160, 150, 140, 130};
  int fd[NCH] = '{110, 220, 130, 240, 150, 250, 160, 230};
  int fe[NCH] = '{250, 110, 249, 109, 200, 120, 230, 140};
  int ff[NCH] = '{180, 181, 182, 183, 184, 185, 186, 187};
  int r1[NCH] = '{150, 150, 107, 150, 150, 150, 150, 150};
  int r2[NCH] = '{150, 150, 150, 150, 150, 253, 150, 150};

  initial begin
    for (int i = 0; i < NCH; i++) fs_frame[i*CW +: CW] = CW'(FSV);

    cyc(3);
    chk("rst_valid", longint'(frame_valid), 0);
    chk("rst_locked", longint'(locked), 0);
    chk("rst_failsafe", longint'(failsafe), 0);
    chk("rst_err", longint'(err_cnt), 0);
    chk_frame("rst_width", fs_frame, 0);
    rst_n = 1'b1;
    held  = fs_frame;
    cyc(400);

    send_good(fa, 480);
    chk("nominal_locked", longint'(locked), 1);
    chk("nominal_err", longint'(err_cnt), 0);

    send_good(fb, 480);
    chk("bounds_locked", longint'(locked), 1);

    send(r1, 480);
    chk("below_min_err", longint'(err_cnt), 1);
    chk("below_min_locked", longint'(locked), 0);
    chk_frame("below_min_hold", held, 0);

    send_good(fa, 480);
    send(r2, 480);
    chk("above_max_err", longint'(err_cnt), 2);
    chk("above_max_locked", longint'(locked), 0);
    chk_frame("above_max_hold", held, 0);

    for (int i = 0; i < 6; i++) tick(150);
    tick(480);
    chk("short_frame_err", longint'(err_cnt), 3);
    chk("short_frame_locked", longint'(locked), 0);
    chk_frame("short_frame_hold", held, 0);

    send_good(fc, SMIN - 1);
    chk("after_short_locked", longint'(locked), 1);

    send(fa, SMIN);
    chk("weak_sync_err", longint'(err_cnt), 3);
    chk("weak_sync_locked", longint'(locked), 1);
    chk_frame("weak_sync_hold", held, 0);

    send_good(fd, 480);
    cyc(FST + 100);
`ifdef PPM_FAILSAFE_EN
    chk("timeout_failsafe", longint'(failsafe), 1);
    chk("timeout_locked", longint'(locked), 0);
    chk_frame("timeout_width", fs_frame, 0);
`else
    chk("timeout_failsafe", longint'(failsafe), 0);
    chk("timeout_locked", longint'(locked), 1);
    chk_frame("timeout_width", held, 0);
`endif

    send_good(fe, 480);
    chk("recover_failsafe", longint'(failsafe), 0);
    chk("recover_locked", longint'(locked), 1);

    for (int i = 0; i < 4; i++) tick(150);
    ppm_n = 1'b0;
    cyc(PW);
    ppm_n = 1'b1;
    cyc(40);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", longint'(frame_valid), 0);
    chk("midrst_locked", longint'(locked), 0);
    chk("midrst_failsafe", longint'(failsafe), 0);
    chk("midrst_err", longint'(err_cnt), 0);
    chk_frame("midrst_width", fs_frame, 0);
    cyc(5);
    rst_n = 1'b1;
    held  = fs_frame;
    cyc(10);

    send(ff, 480);
    chk("nosync_err", longint'(err_cnt), 0);
    chk("nosync_locked", longint'(locked), 0);
    chk_frame("nosync_hold", held, 0);

    send_good(ff, 480);
    chk("final_locked", longint'(locked), 1);

    cyc(20);
    chk("commit_count", longint'(n_commit), longint'(n_pushed));
    chk("queue_empty", longint'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ppm_frame_sequencer.md
# ppm_frame_sequencer

Controller that sequences PPM channel decoding. It qualifies the sync gap, times each of NUM_CH channel slots with one shared interval counter, and validates every width. Only complete, in-bounds frames are committed to the output width bank; a frame timeout drives the bank to a failsafe value. It sits between the `io_in` PPM pin (inverted, as the board delivers it) and the per-channel servo regenerators inside the wrapped user project.

## Interface
Parameters:
- NUM_CH, 8: channels per frame.
- CNT_W, 16: interval counter and width width.
- SYNC_MIN, 36000: minimum gap in cycles that qualifies a sync (3 ms at 12 MHz).
- PULSE_MIN, 10800: minimum legal channel width (0.9 ms).
- PULSE_MAX, 25200: maximum legal channel width (2.1 ms).
- FS_TIMEOUT, 300000: cycles without a commit before failsafe (25 ms).
- FS_VALUE, 18000: width forced into every channel on failsafe and at reset (1.5 ms).

Ports:
- wb_clk_i, in, 1: system clock; the only clock.
- wb_rst_ni, in, 1: reset, asynchronous, active-low.
- ppm_n_i, in, 1: raw inverted PPM input; asynchronous to the clock.
- ch_width_o, out, NUM_CH*CNT_W: committed widths; channel k occupies bits [k*CNT_W +: CNT_W].
- frame_valid_o, out, 1: one-cycle strobe on each commit.
- locked_o, out, 1: at least one good frame and no error since.
- failsafe_o, out, 1: timeout active.
- err_cnt_o, out, 8: saturating count of rejected frames.

## Operation
- Input path: 2-flop synchronizer on ppm_n_i, then inversion. An edge is a 0->1 transition of the de-inverted signal.
- Interval counter: CNT_W bits. Clears to 0 on every edge, otherwise increments and saturates at all-ones. It runs in every state.
- HUNT (reset state): an edge with counter >= SYNC_MIN clears idx and goes to CAPTURE. An edge with a shorter gap only restarts the counter.
- CAPTURE: on an edge, w = counter value before the clear.
  - PULSE_MIN <= w <= PULSE_MAX: write w to shadow[idx] and increment idx. If the new idx == NUM_CH, go to COMMIT.
  - Out of bounds: count an error and go to HUNT.
  - Counter > PULSE_MAX with no edge (short frame or dropout): count an error and go to HUNT. The counter keeps running, so the same gap can qualify as the next sync.
- COMMIT (one cycle): copy shadow to ch_width_o, pulse frame_valid_o, set locked_o, clear failsafe_o and the frame timer, then go to HUNT.
- Error: clear locked_o and increment err_cnt_o (saturates at 255). ch_width_o holds its last committed value.
- Extra pulses after the NUM_CH-th channel are ignored in HUNT, because no sync has been qualified.

## Timing
- Reset values: ch_width_o = FS_VALUE in every channel, frame_valid_o = 0, locked_o = 0, failsafe_o = 0, err_cnt_o = 0. State = HUNT, counter = 0, frame timer = 0.
- Edge latency: a pin transition is seen as an edge 3 cycles later (2 sync flops plus 1 edge register).
- Commit latency: ch_width_o and frame_valid_o update on the cycle after the edge that ends channel NUM_CH.
- Measured width equals the pin edge-to-edge interval in cycles, to within ±1 cycle of synchronizer jitter.
- Boundaries are inclusive: w == PULSE_MIN and w == PULSE_MAX are accepted; a gap == SYNC_MIN qualifies.
- Reset asserted mid-frame discards the shadow immediately and restores the reset values.

## Configuration
- PPM_FAILSAFE_EN defined:
  - A frame timer (ceil(log2(FS_TIMEOUT+1)) bits) counts cycles since the last commit.
  - When it reaches FS_TIMEOUT: failsafe_o = 1, locked_o = 0, every channel of ch_width_o = FS_VALUE. The timer then holds.
  - A commit in the same cycle as the timeout wins: no failsafe, timer cleared.
- PPM_FAILSAFE_EN undefined: no timer; failsafe_o is tied to 0 and ch_width_o holds its last committed frame indefinitely.

## Structure
- Shared package ppm_pkg holds:
  - the state enum (HUNT, CAPTURE, COMMIT);
  - the default timing constants for 12 MHz (SYNC_MIN, PULSE_MIN, PULSE_MAX, FS_TIMEOUT, FS_VALUE);
  - the width type logic [CNT_W-1:0].
- Sub-module ppm_edge_sync: the 2-flop synchronizer plus edge detector, so other PPM blocks can reuse it.
- Everything else (FSM, interval counter, shadow bank, output bank, frame timer, error counter) lives in one module.

## Test plan
- Nominal frame: 4 ms sync, then 8 widths 1.0/1.1/…/1.7 ms (12000…20400 cycles) -> one frame_valid_o strobe; widths 12000…20400 within ±1; locked_o = 1.
- Boundaries: one channel at exactly 10800 and another at exactly 25200 -> accepted. Any width at 10799 or 25201 -> no commit; err_cnt_o increments; locked_o = 0; ch_width_o unchanged.
- Short frame: sync followed by only 6 pulses, then a 4 ms gap -> error on the first cycle the counter reaches 25201. The next full frame commits normally.
- Insufficient sync: gap of 35999 cycles before 8 pulses -> no CAPTURE and no commit. A gap of 36000 cycles -> the frame captures.
- Failsafe (macro on): stop input after a good frame -> at 300000 cycles after the commit, failsafe_o = 1 and all channels = 18000. The next good frame clears failsafe_o. With the macro off, the outputs hold.
- Reset mid-frame: assert wb_rst_ni during channel 4 -> all outputs at reset values immediately, asynchronously. After release, the bench must present a new sync before any commit.
